// File: rtl/spi_ram_arb_pkg.sv
// spi_ram_arb_pkg: widths, opcodes and FSM states shared by the SPI RAM arbiter
// and its lock timer.
package spi_ram_arb_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCKED,
        ST_WAIT_RD
    } state_t;

    function automatic logic [1:0] opcode(input logic [CMD_W-1:0] cmd);
        return cmd[CMD_W-1 -: 2];
    endfunction

    // Address phases keep the lock so the matching data phase follows atomically.
    function automatic logic keeps_lock(input logic [1:0] op);
        return op == OP_WR_ADDR || op == OP_RD_ADDR;
    endfunction

endpackage

// File: rtl/spi_ram_arb_timer.sv
// spi_ram_arb_timer: counts idle cycles of a held lock and flags expiry after
// LOCK_TIMEOUT cycles without an accepted command.
module spi_ram_arb_timer #(
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        cnt <= (!rst_n || clear || !run) ? '0 : cnt + 1'b1;
    end

    assign expired = run && !clear && cnt == CW'(LOCK_TIMEOUT - 1);

endmodule

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: two-requester lock arbiter in front of a single-port SPI RAM.
// Optional lock timeout enabled by defining SPI_RAM_ARB_TIMEOUT_EN.
module spi_ram_arbiter
    import spi_ram_arb_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CMD_W-1:0]  req0_din,
    input  logic              req0_valid,
    output logic              req0_ready,
    output logic [DATA_W-1:0] req0_dout,
    output logic              req0_dout_valid,
    input  logic [CMD_W-1:0]  req1_din,
    input  logic              req1_valid,
    output logic              req1_ready,
    output logic [DATA_W-1:0] req1_dout,
    output logic              req1_dout_valid,
    output logic [CMD_W-1:0]  ram_din,
    output logic              ram_rx_valid,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic              ram_tx_valid,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    state_t           state, state_next;
    logic             last;
    logic             owner;
    logic [CMD_W-1:0] cmd;
    logic [1:0]       op;
    logic             cmd_valid;
    logic             any_req;
    logic             pick;
    logic             accept;
    logic             rd_done;
    logic             expire;
    logic             release_lock;

    assign owner     = grant[1];
    assign cmd       = owner ? req1_din : req0_din;
    assign cmd_valid = owner ? req1_valid : req0_valid;
    assign op        = opcode(cmd);
    assign any_req   = req0_valid || req1_valid;
    // On a tie the requester not served last wins.
    assign pick      = (req0_valid && req1_valid) ? !last : req1_valid;
    assign accept    = state == ST_LOCKED && cmd_valid;
    assign rd_done   = state == ST_WAIT_RD && ram_tx_valid;
    assign release_lock = state != ST_IDLE && state_next == ST_IDLE;

    always_ff @(posedge clk) begin
        state <= !rst_n ? ST_IDLE : state_next;
    end

    always_comb begin
        state_next = expire ? ST_IDLE :
                     state == ST_IDLE    ? (any_req ? ST_LOCKED : ST_IDLE) :
                     state == ST_LOCKED  ? ((!accept || keeps_lock(op)) ? ST_LOCKED :
                                            op == OP_WR_DATA ? ST_IDLE : ST_WAIT_RD) :
                     state == ST_WAIT_RD ? (rd_done ? ST_IDLE : ST_WAIT_RD) :
                     ST_IDLE;
    end

    always_comb begin
        req0_ready = state == ST_LOCKED && grant[0];
        req1_ready = state == ST_LOCKED && grant[1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant           <= 2'b00;
            last            <= 1'b1;
            ram_din         <= '0;
            ram_rx_valid    <= 1'b0;
            req0_dout       <= '0;
            req1_dout       <= '0;
            req0_dout_valid <= 1'b0;
            req1_dout_valid <= 1'b0;
        end else begin
            grant           <= (state == ST_IDLE && any_req) ? (pick ? 2'b10 : 2'b01) :
                               release_lock ? 2'b00 : grant;
            last            <= release_lock ? owner : last;
            ram_rx_valid    <= accept;
            ram_din         <= accept ? cmd : ram_din;
            req0_dout_valid <= rd_done && !owner;
            req1_dout_valid <= rd_done && owner;
            req0_dout       <= (rd_done && !owner) ? ram_dout : req0_dout;
            req1_dout       <= (rd_done && owner) ? ram_dout : req1_dout;
        end
    end

`ifdef SPI_RAM_ARB_TIMEOUT_EN
    spi_ram_arb_timer #(
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (state != ST_IDLE),
        .clear  (accept),
        .expired(expire)
    );

    always_ff @(posedge clk) begin
        timeout_err <= rst_n && expire;
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^LOCK_TIMEOUT;
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/spi_ram_arbiter.md
SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

Interface
REQ-001 Parameter: LOCK_TIMEOUT, 64, idle cycles before a held lock is force-released (used only with ARB_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_din  input  10  requester 0 command word: bits[9:8] opcode, bits[7:0] address/data.
REQ-005 req0_valid  input  1  requester 0 command present.
REQ-006 req0_ready  output  1  requester 0 command accepted this cycle when high with req0_valid.
REQ-007 req0_dout  output  8  read data returned to requester 0.
REQ-008 req0_dout_valid  output  1  one-cycle strobe qualifying req0_dout.
REQ-009 req1_din, req1_valid, req1_ready, req1_dout, req1_dout_valid: same directions, widths and meanings for requester 1.
REQ-010 ram_din  output  10  command word to single-port RAM.
REQ-011 ram_rx_valid  output  1  one-cycle strobe qualifying ram_din.
REQ-012 ram_dout  input  8  RAM read data.
REQ-013 ram_tx_valid  input  1  strobe qualifying ram_dout.
REQ-014 grant  output  2  one-hot current lock owner; 2'b00 when unlocked.
REQ-015 timeout_err  output  1  one-cycle strobe on forced lock release.

Function
REQ-016 States SHALL be IDLE, LOCKED, WAIT_RD.
REQ-017 IDLE: any reqN_valid high -> LOCKED next cycle with grant set; no command accepted while in IDLE.
REQ-018 Tie in IDLE: grant SHALL go to the requester not last served (round-robin); last_served resets to requester 1, so requester 0 wins the first tie.
REQ-019 reqN_ready SHALL be high only in LOCKED with grant[N] set; non-owner ready held low (stalled, never dropped).
REQ-020 Accepted command (valid&ready at edge E): ram_din = command, ram_rx_valid high for exactly the cycle after E.
REQ-021 Opcodes 00 (wr addr) and 10 (rd addr): forwarded, lock retained, stay LOCKED.
REQ-022 Opcode 01 (wr data): forwarded, then IDLE, grant 00, last_served = owner.
REQ-023 Opcode 11 (rd data): forwarded, then WAIT_RD, ready low for both requesters.
REQ-024 WAIT_RD with ram_tx_valid at edge M: owner's dout = ram_dout and dout_valid high for the cycle after M only; then IDLE, last_served = owner.
REQ-025 ram_tx_valid outside WAIT_RD SHALL be ignored; no dout_valid on either port.
REQ-026 Non-owner reqN_dout_valid SHALL never assert; reqN_dout holds last value.
REQ-027 Any opcode sequence is forwarded unchecked; lock release depends only on REQ-022/REQ-024.

Reset
REQ-028 rst_n low at a rising edge: state IDLE, grant 00, ram_din 0, ram_rx_valid 0, both dout 0, both dout_valid 0, both ready 0, timeout_err 0, last_served 1, timeout counter 0.
REQ-029 Reset mid-operation (LOCKED or WAIT_RD) SHALL abandon the transaction; a later ram_tx_valid is ignored per REQ-025.

Configuration
REQ-030 Macro SPI_RAM_ARB_TIMEOUT_EN defined: counter increments each cycle in LOCKED/WAIT_RD, clears on accepted command or on entering IDLE; on reaching LOCK_TIMEOUT -> IDLE, grant 00, timeout_err one-cycle pulse, last_served = owner.
REQ-031 Macro undefined: no counter logic, timeout_err tied 0, lock held indefinitely.

Structure
REQ-032 Package spi_ram_arb_pkg SHALL hold opcode constants OP_WR_ADDR=00, OP_WR_DATA=01, OP_RD_ADDR=10, OP_RD_DATA=11, state enum, CMD_W=10, DATA_W=8.
REQ-033 Sub-module spi_ram_arb_timer (lock timeout counter) SHALL be instantiated only under SPI_RAM_ARB_TIMEOUT_EN.

Verification
REQ-034 req0 sends 10'h0FF then 10'h1CF -> ram_din 0FF then 1CF, each with one-cycle ram_rx_valid; grant 01 -> 00 after 1CF.
REQ-035 req0 sends 10'h2FF, 10'h311; RAM returns ram_dout 8'hCF with ram_tx_valid -> req0_dout 8'hCF, req0_dout_valid one cycle; req1_dout_valid stays 0.
REQ-036 Both valid one cycle after reset -> grant 01 first; after req0's 01-opcode command, grant 10 while req0_valid still high.
REQ-037 req0 locked after 10'h000; req1 presents 10'h005 -> req1_ready 0 until req0 sends 10'h1AA, then req1 granted next arbitration.
REQ-038 With SPI_RAM_ARB_TIMEOUT_EN, LOCK_TIMEOUT=8: req0 sends 10'h311, no ram_tx_valid -> after 8 cycles timeout_err pulses, grant 00; late ram_tx_valid produces no dout_valid.
REQ-039 rst_n low for one edge during WAIT_RD -> all outputs per REQ-028 next cycle; following ram_tx_valid ignored.
